// File: rtl/dadda_mac8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dadda_8 / dadda_mac8                                                |
// | 8x8 Dadda multiplier feeding a streamed multiply-accumulate stage. |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+

module dadda_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  localparam int C_COLS   = 17;
  localparam int C_STAGES = 4;

  // Column-wise bit matrix; column 16 only ever absorbs the (always zero) top carry.
  logic [7:0]  w_cur [C_COLS];
  logic [7:0]  w_nxt [C_COLS];
  logic [3:0]  w_hc  [C_COLS];
  logic [3:0]  w_hn  [C_COLS];
  logic [3:0]  w_d;
  logic [3:0]  w_k;
  logic [3:0]  w_tot;
  logic        w_s;
  logic        w_cy;
  logic [15:0] w_row0;
  logic [15:0] w_row1;

  always_comb begin
    w_d    = 4'd0;
    w_k    = 4'd0;
    w_tot  = 4'd0;
    w_s    = 1'b0;
    w_cy   = 1'b0;
    w_row0 = '0;
    w_row1 = '0;
    for (int c = 0; c < C_COLS; c++) begin
      w_cur[c] = '0;
      w_nxt[c] = '0;
      w_hc[c]  = '0;
      w_hn[c]  = '0;
    end

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        w_cur[i+j][w_hc[i+j][2:0]] = a[j] & b[i];
        w_hc[i+j] = w_hc[i+j] + 4'd1;
      end
    end

    // Dadda height sequence 8 -> 6 -> 4 -> 3 -> 2
    for (int s = 0; s < C_STAGES; s++) begin
      w_d = (s == 0) ? 4'd6 : (s == 1) ? 4'd4 : (s == 2) ? 4'd3 : 4'd2;
      for (int c = 0; c < C_COLS; c++) begin
        w_nxt[c] = '0;
        w_hn[c]  = '0;
      end
      for (int c = 0; c < C_COLS - 1; c++) begin
        w_k   = 4'd0;
        w_tot = w_hc[c] + w_hn[c];
        for (int t = 0; t < 6; t++) begin
          if (w_tot > w_d) begin
            if (w_tot == w_d + 4'd1) begin
              w_s   = w_cur[c][w_k[2:0]] ^ w_cur[c][w_k[2:0] + 3'd1];
              w_cy  = w_cur[c][w_k[2:0]] & w_cur[c][w_k[2:0] + 3'd1];
              w_k   = w_k + 4'd2;
              w_tot = w_tot - 4'd1;
            end else begin
              w_s   = w_cur[c][w_k[2:0]] ^ w_cur[c][w_k[2:0] + 3'd1]
                    ^ w_cur[c][w_k[2:0] + 3'd2];
              w_cy  = (w_cur[c][w_k[2:0]] & w_cur[c][w_k[2:0] + 3'd1])
                    | (w_cur[c][w_k[2:0]] & w_cur[c][w_k[2:0] + 3'd2])
                    | (w_cur[c][w_k[2:0] + 3'd1] & w_cur[c][w_k[2:0] + 3'd2]);
              w_k   = w_k + 4'd3;
              w_tot = w_tot - 4'd2;
            end
            w_nxt[c][w_hn[c][2:0]]     = w_s;
            w_hn[c]                    = w_hn[c] + 4'd1;
            w_nxt[c+1][w_hn[c+1][2:0]] = w_cy;
            w_hn[c+1]                  = w_hn[c+1] + 4'd1;
          end
        end
        for (int r = 0; r < 8; r++) begin
          if ((4'(r) >= w_k) && (4'(r) < w_hc[c])) begin
            w_nxt[c][w_hn[c][2:0]] = w_cur[c][r];
            w_hn[c]                = w_hn[c] + 4'd1;
          end
        end
      end
      for (int c = 0; c < C_COLS; c++) begin
        w_cur[c] = w_nxt[c];
        w_hc[c]  = w_hn[c];
      end
    end

    for (int c = 0; c < 16; c++) begin
      w_row0[c] = w_cur[c][0];
      w_row1[c] = w_cur[c][1];
    end
  end

  assign p = w_row0 + w_row1;

endmodule

module dadda_mac8 #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic             r_v;

  logic [15:0]      w_prod;
  logic [ACC_W:0]   w_sum;
  logic             w_take;

  dadda_8 u_mul (
    .a (r_a),
    .b (r_b),
    .p (w_prod)
  );

  assign w_sum  = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, w_prod};
  assign w_take = in_valid & in_ready;

  assign in_ready  = (r_state == S_ACCUM) && (r_rem != '0);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem   <= len;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_v     <= 1'b0;
            r_state <= (len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_take) begin
            r_a   <= a;
            r_b   <= b;
            r_v   <= 1'b1;
            r_rem <= r_rem - CNT_W'(1);
          end else begin
            r_v   <= 1'b0;
          end
          // Accumulation trails acceptance by one edge; the final add ends the job.
          if (r_v) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
            if (r_rem == '0) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dadda_mac8.sv
`default_nettype none
// Self-checking bench for dadda_mac8: two instances (ACC_W=24 and ACC_W=16)
// share stimulus and are compared against an arithmetic sum-of-products model.
module tb_dadda_mac8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_ready;

  logic        rdy24, ov24, ovf24, busy24;
  logic [23:0] acc24;
  logic        rdy16, ov16, ovf16, busy16;
  logic [15:0] acc16;

  int n_chk = 0;
  int n_err = 0;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  dadda_mac8 #(.ACC_W(24), .CNT_W(8)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(rdy24), .a(a), .b(b),
    .out_valid(ov24), .out_ready(out_ready), .out_acc(acc24),
    .out_ovf(ovf24), .busy(busy24)
  );

  dadda_mac8 #(.ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(rdy16), .a(a), .b(b),
    .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16),
    .out_ovf(ovf16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ov24"},   {31'd0, ov24},   32'd0);
    chk({tag, "_rdy24"},  {31'd0, rdy24},  32'd0);
    chk({tag, "_busy24"}, {31'd0, busy24}, 32'd0);
    chk({tag, "_acc24"},  {8'd0, acc24},   32'd0);
    chk({tag, "_ovf24"},  {31'd0, ovf24},  32'd0);
    chk({tag, "_ov16"},   {31'd0, ov16},   32'd0);
    chk({tag, "_acc16"},  {16'd0, acc16},  32'd0);
    chk({tag, "_ovf16"},  {31'd0, ovf16},  32'd0);
  endtask

  // Plays the job held in qa/qb; gapmask forces idle cycles, gap_pct adds random ones.
  task automatic run_job(input string tag, input int gap_pct,
                         input logic [31:0] gapmask, input int hold);
    longint sum;
    longint e24, e16;
    int L, idx, guard;
    bit gap;
    logic [31:0] hold_acc24;
    sum = 0;
    L = qa.size();
    foreach (qa[i]) sum += longint'(qa[i]) * longint'(qb[i]);
    e24 = sum % (64'd1 << 24);
    e16 = sum % (64'd1 << 16);

    @(negedge clk);
    start = 1'b1;
    len   = 8'(L);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy24}, 32'd1);
    idx = 0;
    guard = 0;
    while (idx < L && guard < 4 * L + 40) begin
      gap = (guard < 32 && gapmask[guard]) || ($urandom_range(99) < gap_pct);
      in_valid = !gap;
      a = gap ? 8'($urandom) : 8'(qa[idx]);
      b = gap ? 8'($urandom) : 8'(qb[idx]);
      chk({tag, "_in_ready"}, {31'd0, rdy24 & rdy16}, 32'd1);
      chk({tag, "_no_early_valid"}, {31'd0, ov24}, 32'd0);
      @(negedge clk);
      if (!gap) idx++;
      guard++;
    end
    if (idx < L) chk({tag, "_accept_timeout"}, 32'(idx), 32'(L));
    in_valid = 1'b0;
    if (L > 0) begin
      chk({tag, "_valid_lat0"}, {31'd0, ov24}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_valid24"},   {31'd0, ov24},   32'd1);
    chk({tag, "_valid16"},   {31'd0, ov16},   32'd1);
    chk({tag, "_ready_done"}, {31'd0, rdy24}, 32'd0);
    chk({tag, "_acc24"},     {8'd0, acc24},   32'(e24));
    chk({tag, "_ovf24"},     {31'd0, ovf24},  {31'd0, sum >= (64'd1 << 24)});
    chk({tag, "_acc16"},     {16'd0, acc16},  32'(e16));
    chk({tag, "_ovf16"},     {31'd0, ovf16},  {31'd0, sum >= (64'd1 << 16)});
    hold_acc24 = {8'd0, acc24};

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = (h == 1);
      in_valid  = 1'b1;
      a         = 8'($urandom);
      b         = 8'($urandom);
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, ov24 & ov16}, 32'd1);
      chk({tag, "_hold_acc"},   {8'd0, acc24}, 32'(e24));
    end
    in_valid  = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {31'd0, ov24 | ov16},     32'd0);
    chk({tag, "_idle_busy"},  {31'd0, busy24 | busy16}, 32'd0);
    @(negedge clk);
    chk({tag, "_start_not_taken"}, {31'd0, busy24}, 32'd0);
    chk({tag, "_acc_kept"}, {8'd0, acc24}, hold_acc24);
  endtask

  task automatic push(input int x, input int y);
    qa.push_back(x);
    qb.push_back(y);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_all_zero($sformatf("idle%0d", i));
    end

    qa.delete(); qb.delete();
    push(3, 4); push(10, 10); push(255, 255);
    run_job("single", 0, 32'h0, 2);

    qa.delete(); qb.delete();
    run_job("zero_len", 0, 32'h0, 1);

    qa.delete(); qb.delete();
    push(7, 9); push(2, 128);
    run_job("backpress", 0, 32'h2, 5);

    qa.delete(); qb.delete();
    push(255, 255); push(255, 255);
    run_job("overflow", 0, 32'h0, 0);
    qa.delete(); qb.delete();
    push(1, 1);
    run_job("after_ovf", 0, 32'h0, 0);

    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 8'd200; b = 8'd100;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("midreset_rel");
    qa.delete(); qb.delete();
    push(5, 6);
    run_job("post_reset", 0, 32'h0, 1);

    for (int j = 0; j < 10; j++) begin
      qa.delete(); qb.delete();
      for (int k = 0; k < int'($urandom_range(12, 1)); k++)
        push(int'($urandom_range(255)), int'($urandom_range(255)));
      run_job($sformatf("rand%0d", j), 30, 32'h0, int'($urandom_range(3)));
    end

    qa.delete(); qb.delete();
    for (int k = 0; k < 255; k++) push(255, 255);
    run_job("max_len", 0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
